// File: rtl/iir_cascada_pkg.sv
// Shared types, word widths and arithmetic helpers for the iir_cascada biquad cascade.
// Build option: IIR_CASCADA_SAT_EN selects clamping (with overflow flag) instead of wrapping.
package iir_cascada_pkg;

  localparam int P  = 8;
  localparam int F  = 14;
  localparam int W  = 1 + P + F;
  localparam int PC = 8;
  localparam int FC = 14;
  localparam int CW = 1 + PC + FC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int K_A1 = 0;
  localparam int K_A2 = 1;
  localparam int K_B0 = 2;
  localparam int K_B1 = 3;
  localparam int K_B2 = 4;

  function automatic int acc_width(input int w, input int pc);
    return w + pc + 3;
  endfunction

  localparam int ACC_W = acc_width(W, PC);

  typedef struct packed {
    logic signed [W-1:0] val;
    logic                ovf;
  } red_t;

  // Width reduction of an accumulator value back to a sample/state word.
  function automatic red_t reduce(input logic signed [ACC_W-1:0] a);
    red_t r;
`ifdef IIR_CASCADA_SAT_EN
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    sat_max = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    sat_min = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
    if (a > sat_max) begin
      r.val = sat_max[W-1:0];
      r.ovf = 1'b1;
    end else if (a < sat_min) begin
      r.val = sat_min[W-1:0];
      r.ovf = 1'b1;
    end else begin
      r.val = a[W-1:0];
      r.ovf = 1'b0;
    end
`else
    r.val = a[W-1:0];
    r.ovf = 1'b0;
`endif
    return r;
  endfunction

endpackage

// File: rtl/iir_cascada_if.sv
// Sample stream and coefficient-write bus of the iir_cascada filter.
interface iir_cascada_if #(
  parameter int W  = 23,
  parameter int CW = 23,
  parameter int AW = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  uk;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic signed [W-1:0]  yk;

  modport master (
    output in_valid, uk, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, yk
  );

  modport slave (
    input  in_valid, uk, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, yk
  );
endinterface

// File: rtl/iir_cascada_mac.sv
// Shared multiplier-accumulator: product scaled by 2^-FC (floor), then loaded or accumulated.
module iir_mac #(
  parameter int W     = 23,
  parameter int CW    = 23,
  parameter int FC    = 14,
  parameter int ACC_W = 34
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [ACC_W-1:0] addend,
  input  logic signed [W-1:0]     a_in,
  input  logic signed [CW-1:0]    c_in,
  output logic signed [ACC_W-1:0] sum
);
  logic signed [W+CW-1:0]  prod_s;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  // The scaled product always fits the accumulator, so the cast only drops sign copies.
  always_comb begin
    prod_s     = a_in * c_in;
    prod_ext_s = ACC_W'(prod_s >>> FC);
    if (load) begin
      acc_d = addend + prod_ext_s;
    end else begin
      acc_d = acc_q + prod_ext_s;
    end
    if (en) begin
      sum = acc_d;
    end else begin
      sum = acc_q;
    end
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end else begin
      acc_q <= acc_q;
    end
  end
endmodule

// File: rtl/iir_cascada.sv
// Cascade of N_SEC direct-form-II biquads sharing one MAC, five MAC cycles per section.
// Build option: IIR_CASCADA_SAT_EN (saturating reductions, sticky ovf); default wraps.
module iir_cascada
  import iir_cascada_pkg::*;
#(
  parameter int N_SEC = 2
) (
  input  logic            sclk,
  input  logic            rst,
  iir_cascada_if.slave    bus,
  input  logic            state_clr,
  output logic            ovf
);
  localparam int NCOEF = 5 * N_SEC;
  localparam int AW    = $clog2(NCOEF);
  localparam int SW    = (N_SEC > 1) ? $clog2(N_SEC) : 1;

  state_e                  state_q, state_d;
  logic [2:0]              step_q, step_d;
  logic [SW-1:0]           sec_q, sec_d;
  logic signed [W-1:0]     u_q, u_d;
  logic signed [W-1:0]     f_q, f_d;
  logic signed [W-1:0]     yk_q, yk_d;
  logic                    out_valid_q, out_valid_d;
  logic                    ovf_q, ovf_d;
  logic signed [CW-1:0]    coef_q [NCOEF];
  logic signed [CW-1:0]    coef_d [NCOEF];
  logic signed [W-1:0]     f1_q [N_SEC];
  logic signed [W-1:0]     f1_d [N_SEC];
  logic signed [W-1:0]     f2_q [N_SEC];
  logic signed [W-1:0]     f2_d [N_SEC];

  logic [AW-1:0]           base_s;
  logic                    mac_load_s;
  logic signed [W-1:0]     mac_a_s;
  logic signed [CW-1:0]    mac_c_s;
  logic signed [ACC_W-1:0] mac_add_s;
  logic signed [ACC_W-1:0] sum_s;
  red_t                    red_s;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.yk        = yk_q;
  assign ovf           = ovf_q;

  // Operand selection for the shared MAC by section and step.
  always_comb begin
    base_s     = AW'(sec_q) * AW'(3'd5);
    mac_load_s = 1'b0;
    mac_a_s    = '0;
    mac_c_s    = '0;
    mac_add_s  = '0;
    case (step_q)
      3'd0: begin
        mac_load_s = 1'b1;
        mac_a_s    = f1_q[sec_q];
        mac_c_s    = coef_q[base_s + AW'(K_A1)];
        mac_add_s  = {{(ACC_W-W){u_q[W-1]}}, u_q};
      end
      3'd1: begin
        mac_a_s = f2_q[sec_q];
        mac_c_s = coef_q[base_s + AW'(K_A2)];
      end
      3'd2: begin
        mac_load_s = 1'b1;
        mac_a_s    = f_q;
        mac_c_s    = coef_q[base_s + AW'(K_B0)];
      end
      3'd3: begin
        mac_a_s = f1_q[sec_q];
        mac_c_s = coef_q[base_s + AW'(K_B1)];
      end
      3'd4: begin
        mac_a_s = f2_q[sec_q];
        mac_c_s = coef_q[base_s + AW'(K_B2)];
      end
      default: begin
        mac_load_s = 1'b1;
      end
    endcase
  end

  iir_mac #(.W(W), .CW(CW), .FC(FC), .ACC_W(ACC_W)) u_mac (
    .sclk   (sclk),
    .rst    (rst),
    .en     (state_q == MAC),
    .load   (mac_load_s),
    .addend (mac_add_s),
    .a_in   (mac_a_s),
    .c_in   (mac_c_s),
    .sum    (sum_s)
  );

  // Sequencer and next-state for all filter storage.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    sec_d       = sec_q;
    u_d         = u_q;
    f_d         = f_q;
    yk_d        = yk_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;
    coef_d      = coef_q;
    f1_d        = f1_q;
    f2_d        = f2_q;
    red_s       = reduce(sum_s);
    case (state_q)
      IDLE: begin
        if (bus.coef_we && (bus.coef_addr < AW'(NCOEF))) begin
          coef_d[bus.coef_addr] = bus.coef_data;
        end else begin
          coef_d = coef_q;
        end
        if (state_clr) begin
          for (int i = 0; i < N_SEC; i++) begin
            f1_d[i] = '0;
            f2_d[i] = '0;
          end
          ovf_d = 1'b0;
        end else begin
          ovf_d = ovf_q;
        end
        if (bus.in_valid) begin
          u_d     = bus.uk;
          step_d  = 3'd0;
          sec_d   = '0;
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        if (step_q == 3'd1) begin
          f_d   = red_s.val;
          ovf_d = ovf_q | red_s.ovf;
        end else begin
          f_d = f_q;
        end
        // Section output becomes the next section's input (or the cascade result).
        if (step_q == 3'd4) begin
          u_d          = red_s.val;
          ovf_d        = ovf_q | red_s.ovf;
          f2_d[sec_q]  = f1_q[sec_q];
          f1_d[sec_q]  = f_q;
          step_d       = 3'd0;
          if (sec_q == SW'(N_SEC - 1)) begin
            state_d = DONE;
          end else begin
            sec_d = sec_q + SW'(1'b1);
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE: begin
        yk_d        = u_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      step_q      <= 3'd0;
      sec_q       <= '0;
      u_q         <= '0;
      f_q         <= '0;
      yk_q        <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        coef_q[i] <= '0;
      end
      for (int i = 0; i < N_SEC; i++) begin
        f1_q[i] <= '0;
        f2_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      sec_q       <= sec_d;
      u_q         <= u_d;
      f_q         <= f_d;
      yk_q        <= yk_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      coef_q      <= coef_d;
      f1_q        <= f1_d;
      f2_q        <= f2_d;
    end
  end
endmodule

// File: tb/tb_iir_cascada.sv
// Scoreboard bench for iir_cascada: directed samples, expected outputs queued at accept time.
module tb_iir_cascada;
  import iir_cascada_pkg::*;

  localparam int NS  = 2;
  localparam int AWT = 4;
`ifdef IIR_CASCADA_SAT_EN
  localparam longint OVF_Y   = 4194303;
  localparam logic   OVF_EXP = 1'b1;
`else
  localparam longint OVF_Y   = -4;
  localparam logic   OVF_EXP = 1'b0;
`endif

  logic sclk = 1'b0;
  logic rst = 1'b0;
  logic state_clr = 1'b0;
  logic ovf;

  iir_cascada_if #(.W(W), .CW(CW), .AW(AWT)) bus ();

  iir_cascada #(.N_SEC(NS)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .bus       (bus),
    .state_clr (state_clr),
    .ovf       (ovf)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    longint y;
    logic   o;
    longint t;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge sclk) begin
    if (rst && bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got yk=%0d, expected no output", bus.yk);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("yk", longint'(bus.yk), e.y);
        chk("ovf", longint'(ovf), longint'(e.o));
        chk("latency", (longint'($time) - e.t - 5) / 10, 11);
      end
    end
  end

  task automatic push_exp(input longint y, input logic o);
    exp_t e;
    e.y = y;
    e.o = o;
    e.t = longint'($time);
    q.push_back(e);
  endtask

  task automatic send(input longint u, input longint y, input logic o, input logic clr);
    int n;
    n = 0;
    @(negedge sclk);
    while (!bus.in_ready && n < 100) begin
      @(negedge sclk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0, expected 1");
    end else begin
      bus.in_valid = 1'b1;
      bus.uk       = W'(u);
      state_clr    = clr;
      @(posedge sclk);
      push_exp(y, o);
      #1;
      bus.in_valid = 1'b0;
      state_clr    = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge sclk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
      q.delete();
    end
    @(negedge sclk);
  endtask

  task automatic wcoef(input int addr, input longint data);
    @(negedge sclk);
    bus.coef_we   = 1'b1;
    bus.coef_addr = AWT'(addr);
    bus.coef_data = CW'(data);
    @(posedge sclk);
    #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic set_sec(input int s, input longint a1, input longint a2,
                         input longint b0, input longint b1, input longint b2);
    wcoef(5 * s + K_A1, a1);
    wcoef(5 * s + K_A2, a2);
    wcoef(5 * s + K_B0, b0);
    wcoef(5 * s + K_B1, b1);
    wcoef(5 * s + K_B2, b2);
  endtask

  task automatic clear_states();
    @(negedge sclk);
    state_clr = 1'b1;
    @(posedge sclk);
    #1;
    state_clr = 1'b0;
  endtask

  initial begin
    logic r;
    longint ta[$];
    bus.in_valid  = 1'b0;
    bus.uk        = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;

    // Reset state
    repeat (3) @(negedge sclk);
    chk("rst_yk", longint'(bus.yk), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_ovf", longint'(ovf), 0);
    rst = 1'b1;
    @(negedge sclk);
    chk("rst_in_ready", longint'(bus.in_ready), 1);

    // Pass-through, negative samples and floor rounding
    set_sec(0, 0, 0, 16384, 0, 0);
    set_sec(1, 0, 0, 16384, 0, 0);
    send(1000, 1000, 1'b0, 1'b0);
    send(-1000, -1000, 1'b0, 1'b0);
    drain();
    set_sec(0, 0, 0, 8192, 0, 0);
    set_sec(1, 0, 0, 8192, 0, 0);
    send(-3, -1, 1'b0, 1'b0);
    drain();

    // Coefficient write while busy is dropped, while idle takes effect
    set_sec(0, 0, 0, 16384, 0, 0);
    set_sec(1, 0, 0, 16384, 0, 0);
    send(1000, 1000, 1'b0, 1'b0);
    wcoef(K_B0, 0);
    drain();
    wcoef(K_B0, 0);
    send(1000, 0, 1'b0, 1'b0);
    drain();

    // Out-of-range addresses leave the bank alone
    wcoef(K_B0, 16384);
    for (int a = 5 * NS; a < 16; a++) wcoef(a, 0);
    send(777, 777, 1'b0, 1'b0);
    drain();

    // Back-to-back accepts with in_valid held high
    bus.uk = W'(500);
    for (int i = 0; i < 37; i++) begin
      @(negedge sclk);
      bus.in_valid = 1'b1;
      r = bus.in_ready;
      @(posedge sclk);
      if (r) begin
        push_exp(500, 1'b0);
        ta.push_back(longint'($time));
      end
    end
    #1;
    bus.in_valid = 1'b0;
    chk("hs_accepts", longint'(ta.size()), 4);
    for (int i = 1; i < ta.size(); i++) chk("hs_spacing", (ta[i] - ta[i-1]) / 10, 12);
    drain();

    // Impulse response, then state clear (separate and coincident)
    set_sec(0, 8192, 0, 16384, 0, 0);
    set_sec(1, 0, 0, 16384, 0, 0);
    clear_states();
    send(16384, 16384, 1'b0, 1'b0);
    send(0, 8192, 1'b0, 1'b0);
    send(0, 4096, 1'b0, 1'b0);
    send(0, 2048, 1'b0, 1'b0);
    send(0, 1024, 1'b0, 1'b0);
    drain();
    clear_states();
    send(0, 0, 1'b0, 1'b0);
    send(16384, 16384, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b1);
    drain();

    // Overflow through both sections
    set_sec(0, 0, 0, 32768, 0, 0);
    set_sec(1, 0, 0, 32768, 0, 0);
    send(4194303, OVF_Y, OVF_EXP, 1'b0);
    drain();
    chk("ovf_sticky", longint'(ovf), longint'(OVF_EXP));
    clear_states();
    @(negedge sclk);
    chk("ovf_cleared", longint'(ovf), 0);

    // Reset during MAC step 3 of section 0
    set_sec(0, 0, 0, 16384, 0, 0);
    set_sec(1, 0, 0, 16384, 0, 0);
    @(negedge sclk);
    bus.in_valid = 1'b1;
    bus.uk       = W'(1000);
    @(posedge sclk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge sclk);
    rst = 1'b1;
    repeat (20) @(negedge sclk);
    chk("abort_yk", longint'(bus.yk), 0);
    chk("abort_in_ready", longint'(bus.in_ready), 1);
    chk("abort_ovf", longint'(ovf), 0);
    send(1000, 0, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iir_cascada.md
Name: iir_cascada

Overview:
- Parametrised successor to the single-section direct-form-II biquad.
- Computes a cascade of N_SEC biquad sections on one time-multiplexed multiplier-accumulator, driven by an FSM.
- Coefficients live in a runtime-writable register bank. Samples enter and leave through a valid/ready handshake.
- Sits between the sample-rate front end and the output DAC path.

Parameters:
p, 8, integer bits of sample/state words
f, 14, fractional bits of sample/state words
Width, 1+p+f, sample/state word width (signed)
pc, 8, integer bits of coefficients
fc, 14, fractional bits of coefficients
CW, 1+pc+fc, coefficient width (signed)
N_SEC, 2, number of cascaded sections (1..8)
AW, clog2(5*N_SEC), coefficient address width

Ports:
sclk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
uk  in  Width  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  AW  coefficient index, 5*s+k, k: 0=a1 1=a2 2=b0 3=b1 4=b2
coef_data  in  CW  signed coefficient value
state_clr  in  1  synchronous clear of all delay states
out_valid  out  1  one-cycle pulse, yk valid
yk  out  Width  signed cascade output, held until next result
ovf  out  1  sticky overflow flag

Behaviour:
- Reset (rst=0, async):
  - Delay states f1/f2 of all sections = 0; all coefficients = 0.
  - yk = 0, out_valid = 0, ovf = 0, FSM = IDLE.
  - After release, in_ready = 1.
- Per-section equations, same sign convention as the existing biquad (additions only):
  - f = u + a1*f1 + a2*f2
  - y = b0*f + b1*f1 + b2*f2
  - The y of section s is the u of section s+1; the y of the last section drives yk.
- Arithmetic:
  - Each product is the full Width+CW bits, then arithmetically shifted right by fc (truncation toward -inf).
  - Accumulator is Width+pc+3 bits.
  - f and y are reduced to Width at the end of their accumulation (see Optional Feature).
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch uk and go to MAC with step = 0, sec = 0.
  - MAC: 5 cycles per section.
    - step 0: acc = u + a1*f1
    - step 1: acc += a2*f2, then reduce to f
    - step 2: acc = b0*f
    - step 3: acc += b1*f1
    - step 4: acc += b2*f2, then reduce to y; f2 <= f1, f1 <= f; sec++
    - After sec = N_SEC-1, step 4, go to DONE.
  - DONE: yk <= result, out_valid = 1 for exactly this cycle, then go to IDLE.
- Timing:
  - out_valid is high 5*N_SEC+1 cycles after the accept edge.
  - Minimum sample period is 5*N_SEC+2 cycles.
  - in_ready = 0 in MAC and DONE. There is no output backpressure.
- Coefficient writes:
  - Take effect only when the FSM is IDLE.
  - Writes in MAC/DONE are dropped.
  - Addresses >= 5*N_SEC are ignored.
  - A write coincident with a sample accept applies before that sample's computation.
- state_clr:
  - Honoured only in IDLE; zeroes all f1/f2; coefficients are untouched.
  - If coincident with an accept, the sample is computed with zeroed states.
- Reset mid-operation aborts the computation with no out_valid; all values return to their reset values.

Optional Feature:
- Macro: IIR_CASCADA_SAT_EN
- Defined:
  - Each Width reduction clamps to [-2^(Width-1), 2^(Width-1)-1].
  - Any clamp sets ovf; ovf is sticky until reset or state_clr.
- Undefined:
  - Reduction keeps the low Width bits (two's-complement wrap).
  - ovf is tied to 0.

Decomposition:
- Package iir_cascada_pkg holds:
  - FSM state enum (IDLE, MAC, DONE)
  - Coefficient index constants K_A1=0, K_A2=1, K_B0=2, K_B1=3, K_B2=4
  - A function returning the accumulator width
  - The saturate/wrap reduction function
- One sub-module, iir_mac:
  - Signed multiply, shift by fc, accumulate-or-load, registered accumulator.
  - Instanced once in iir_cascada.

Test Plan:
- Pass-through: N_SEC=2, b0=16384 (1.0) in both sections, others 0; uk=1000 -> yk=1000, out_valid exactly 11 cycles after accept.
- Impulse: sec0 a1=8192 (0.5), b0=16384; sec1 b0=16384; uk=16384 then zeros -> yk sequence 16384, 8192, 4096, 2048, 1024.
- Overflow: b0=32768 (2.0) both sections, uk=4194303:
  - with IIR_CASCADA_SAT_EN -> yk=4194303, ovf=1
  - without the macro -> yk=-4 (double wrap), ovf=0
- Handshake: in_valid held high -> accepts spaced exactly 12 cycles; in_ready=0 between accepts; exactly one out_valid per accept.
- Busy write: coef_we with b0=0 issued during MAC -> dropped, next result unchanged; the same write in IDLE -> next yk=0.
- Reset/clear:
  - rst low at MAC step 3 -> no out_valid, yk=0, coefs 0, in_ready=1 after release.
  - state_clr after the impulse -> next zero input gives yk=0.
